ring_johnson_decoder: RTL and testbench
=======================================

# ring_johnson_decoder

Receive-side checker for the ring/Johnson counter generators on the DE2 lab boards. It samples an N-bit ring (one-hot) or Johnson code bus and decodes each legal code to a binary step index. It checks that successive samples advance by exactly one step, locks after a run of good steps, and counts sequence faults. It sits between the board-side counter output, or the GPIO loopback, and the LED/7-segment display logic.

## Interface
Parameters:
- N, 5: code width in bits; N ≥ 2.
- LOCK_CNT, 3: consecutive correct steps required to enter LOCKED; range 1..15.
- ERR_W, 8: width of the fault counter.
- IDX_W (localparam), $clog2(2*N): index width; 4 for N=5.

Ports (reset reset, asynchronous, active-low; clock clk):
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- mode  in  1  code type: 0 = ring (one-hot), 1 = Johnson.
- valid  in  1  code is sampled on this cycle.
- code  in  [0:N-1]  code bus; bit 0 is the fill/entry bit.
- clr_err  in  1  synchronous clear of err_cnt.
- idx  out  IDX_W  decoded step index of the last legal sample.
- idx_vld  out  1  idx updated this cycle; pulse.
- legal  out  1  last sample was a legal code; held.
- locked  out  1  FSM is in LOCKED.
- err  out  1  one-cycle fault pulse, LOCKED only.
- err_cnt  out  ERR_W  saturating fault count.

## Operation
Legal codes:
- Ring: exactly one bit set. idx = position of the set bit, 0..N-1. Successor of j is (j+1) mod N.
- Johnson: 2N codes.
  - Step t in 0..N: bits 0..t-1 are 1, the rest are 0.
  - Step t in N+1..2N-1: bits 0..t-N-1 are 0, the rest are 1.
  - Successor is (t+1) mod 2N. With N=5: 00000 → 10000 → … → 11111 → 01111 → … → 00001 → 00000.
- Any other pattern is illegal.

FSM states: HUNT, CHECK, LOCKED. Only cycles with valid=1 are evaluated; valid=0 holds all state and outputs, and idx_vld and err are 0.
- HUNT: a legal code loads idx and clears the run counter, then goes to CHECK. An illegal code stays in HUNT.
- CHECK: a legal code equal to successor(idx) updates idx and increments the run counter. When the counter reaches LOCK_CNT, go to LOCKED. A legal non-successor reloads idx, clears the run counter and stays in CHECK. An illegal code goes to HUNT. No errors are counted in CHECK.
- LOCKED: a legal successor updates idx. An illegal code or wrong step pulses err, increments err_cnt and goes to HUNT; idx is not updated.

Mode handling:
- mode is sampled with each valid.
- A mode different from the value latched at the last valid sample forces HUNT without an error.
- That same sample is then evaluated as a HUNT sample under the new mode.

Outputs:
- legal reflects every valid sample.
- idx_vld pulses whenever idx is written.
- err_cnt saturates at 2^ERR_W−1.
- When clr_err and a fault occur in the same cycle, the clear wins: err_cnt=0, but err still pulses.

## Timing
- All outputs are registered. Latency is 1 cycle from the valid sample edge to idx, idx_vld, legal, locked and err.
- Reset clears everything immediately, including mid-sequence: state HUNT, idx=0, idx_vld=0, legal=0, locked=0, err=0, err_cnt=0, latched mode=0, run counter=0.
- The first valid sample after reset deassertion is processed normally.
- Index wrap: ring N-1→0 and Johnson 2N-1→0 are correct steps.

## Configuration
- RJD_STALL_OK_EN defined: a legal code equal to the current idx (a repeat) in CHECK or LOCKED is a stall. On a stall, state and run counter are unchanged, idx_vld=0 and no error is raised.
- RJD_STALL_OK_EN undefined: a repeat is a wrong step. In CHECK it reloads and restarts the run; in LOCKED it is a fault.

## Test plan
- Ring lock (N=5, mode=0, LOCK_CNT=3): send 10000, 01000, 00100, 00010 on consecutive valid cycles → idx 0,1,2,3; locked=1 one cycle after the 4th sample; err_cnt=0.
- Johnson full cycle (mode=1): send all 10 codes from 00000 twice → idx 0..9 then wraps 9→0; locked stays 1 after lock; err never asserted.
- LOCKED fault: while locked at idx=2 (ring), send 11000 (illegal) → err=1 for one cycle, err_cnt=1, legal=0, locked=0, idx stays 2. Then send 00001 → state goes to CHECK with idx=4.
- Saturation and clear (ERR_W=2): force 5 locked faults → err_cnt stops at 3. Assert clr_err on the same cycle as a fault → err_cnt=0 and err=1.
- Reset and mode switch: locked in ring, pull reset low mid-run → all outputs 0 immediately. After reset, lock in ring, then flip mode=1 with code 11100 → no err, idx=3, state CHECK.
- Stall: locked at Johnson idx=4, repeat 11110 → with RJD_STALL_OK_EN, locked stays 1, idx_vld=0, err=0; without it, err=1 and err_cnt increments.

Source files
------------

// File: rtl/ring_johnson_decoder.sv
// Ring / Johnson code receive checker: decodes each sample to a step index, verifies
// single-step advance, locks after a run of good steps and counts faults. Option macro: RJD_STALL_OK_EN.
module ring_johnson_decoder #(
    parameter int  N        = 5,
    parameter int  LOCK_CNT = 3,
    parameter int  ERR_W    = 8,
    localparam int IDX_W    = $clog2(2 * N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic             valid,
    input  logic [0:N-1]     code,
    input  logic             clr_err,
    output logic [IDX_W-1:0] idx,
    output logic             idx_vld,
    output logic             legal,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

`ifdef RJD_STALL_OK_EN
    localparam bit STALL_OK = 1'b1;
`else
    localparam bit STALL_OK = 1'b0;
`endif

    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    state_t             state_q;
    state_t             st_eff;
    logic [IDX_W-1:0]   idx_q;
    logic               idx_vld_q;
    logic               legal_q;
    logic               err_q;
    logic [ERR_W-1:0]   err_cnt_q;
    logic               mode_q;
    logic [3:0]         run_q;
    logic [3:0]         run_d;
    logic               dec_legal;
    logic [IDX_W-1:0]   dec_idx;
    logic [IDX_W-1:0]   succ_idx;

    // Returns {legal, index}; Johnson codes are matched against every one of the 2N patterns.
    function automatic logic [IDX_W:0] decode(input logic m, input logic [0:N-1] c);
        logic             lg;
        logic [IDX_W-1:0] ix;
        logic [0:N-1]     pat;
        int               ones;
        lg   = 1'b0;
        ix   = '0;
        ones = 0;
        if (!m) begin
            for (int b = 0; b < N; b++) begin
                if (c[b]) begin
                    ones++;
                    ix = IDX_W'(b);
                end
            end
            lg = (ones == 1);
            if (!lg) ix = '0;
        end else begin
            for (int t = 0; t < 2 * N; t++) begin
                for (int b = 0; b < N; b++) begin
                    pat[b] = (t <= N) ? (b < t) : (b >= t - N);
                end
                if (pat == c) begin
                    lg = 1'b1;
                    ix = IDX_W'(t);
                end
            end
        end
        return {lg, ix};
    endfunction

    function automatic logic [IDX_W-1:0] successor(input logic m, input logic [IDX_W-1:0] cur);
        int lim;
        lim = m ? 2 * N : N;
        if (int'(cur) + 1 >= lim) return '0;
        return cur + IDX_W'(1);
    endfunction

    always_comb begin
        {dec_legal, dec_idx} = decode(mode, code);
        succ_idx             = successor(mode, idx_q);
        st_eff               = (mode != mode_q) ? HUNT : state_q;
        run_d                = run_q + 4'd1;
    end

    // A mode change re-evaluates the sample as a fresh HUNT sample, never as a fault.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= HUNT;
            idx_q     <= '0;
            idx_vld_q <= 1'b0;
            legal_q   <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            mode_q    <= 1'b0;
            run_q     <= '0;
        end else begin
            idx_vld_q <= 1'b0;
            err_q     <= 1'b0;
            if (valid) begin
                mode_q  <= mode;
                legal_q <= dec_legal;
                case (st_eff)
                    HUNT: begin
                        if (dec_legal) begin
                            idx_q     <= dec_idx;
                            idx_vld_q <= 1'b1;
                            run_q     <= '0;
                            state_q   <= CHECK;
                        end else begin
                            state_q   <= HUNT;
                        end
                    end
                    CHECK: begin
                        if (!dec_legal) begin
                            state_q <= HUNT;
                        end else if (dec_idx == succ_idx) begin
                            idx_q     <= dec_idx;
                            idx_vld_q <= 1'b1;
                            run_q     <= run_d;
                            if (int'(run_d) >= LOCK_CNT) state_q <= LOCKED;
                        end else if (STALL_OK && dec_idx == idx_q) begin
                            state_q <= CHECK;
                        end else begin
                            idx_q     <= dec_idx;
                            idx_vld_q <= 1'b1;
                            run_q     <= '0;
                        end
                    end
                    LOCKED: begin
                        if (dec_legal && dec_idx == succ_idx) begin
                            idx_q     <= dec_idx;
                            idx_vld_q <= 1'b1;
                        end else if (STALL_OK && dec_legal && dec_idx == idx_q) begin
                            state_q <= LOCKED;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= HUNT;
                            if (err_cnt_q != ERR_MAX) err_cnt_q <= err_cnt_q + ERR_W'(1);
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end
            // Clear takes priority over a simultaneous fault increment; err still pulses.
            if (clr_err) err_cnt_q <= '0;
        end
    end

    assign idx     = idx_q;
    assign idx_vld = idx_vld_q;
    assign legal   = legal_q;
    assign locked  = (state_q == LOCKED);
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_ring_johnson_decoder.sv
// Scoreboard bench for ring_johnson_decoder (N=5, LOCK_CNT=3, ERR_W=2); expectations are hand-derived
// from the code tables and pushed when each sample is driven.
module tb_ring_johnson_decoder;

    localparam int OW = 10;  // {idx[3:0], idx_vld, legal, locked, err, err_cnt[1:0]}

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       mode = 1'b0;
    logic       valid = 1'b0;
    logic [0:4] code = '0;
    logic       clr_err = 1'b0;
    logic [3:0] idx;
    logic       idx_vld, legal, locked, err;
    logic [1:0] err_cnt;

    int vec_cnt = 0;
    int miss_cnt = 0;
    logic [OW-1:0] sb[$];

    logic [0:4] rc [5]  = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
    logic [0:4] jc [10] = '{5'b00000, 5'b10000, 5'b11000, 5'b11100, 5'b11110,
                            5'b11111, 5'b01111, 5'b00111, 5'b00011, 5'b00001};

    ring_johnson_decoder #(.N(5), .LOCK_CNT(3), .ERR_W(2)) dut (
        .clk(clk), .reset(reset), .mode(mode), .valid(valid), .code(code), .clr_err(clr_err),
        .idx(idx), .idx_vld(idx_vld), .legal(legal), .locked(locked), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] E(int i, bit v, bit l, bit k, bit e, int c);
        return {4'(i), v, l, k, e, 2'(c)};
    endfunction

    function automatic logic [OW-1:0] outs();
        return {idx, idx_vld, legal, locked, err, err_cnt};
    endfunction

    task automatic drive(input logic v, input logic m, input logic [0:4] c, input logic clr,
                         input logic [OW-1:0] e);
        valid = v; mode = m; code = c; clr_err = clr;
        sb.push_back(e);
        @(posedge clk); #1;
        valid = 1'b0; clr_err = 1'b0;
    endtask

    task automatic test_reset();
        logic [OW-1:0] got, e;
        drive(1'b1, 1'b0, 5'b10000, 1'b0, E(0, 0, 0, 0, 0, 0));
        got = outs(); e = sb.pop_front(); vec_cnt++;
        if (got !== e) begin miss_cnt++; $display("FAIL reset_hold got %b expected %b", got, e); end
        reset = 1'b1;
    endtask

    task automatic test_ring_lock();
        logic [OW-1:0] got, e;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b0, rc[k % 5], 1'b0, E(k % 5, 1, 1, k >= 3, 0, 0));
            got = outs(); e = sb.pop_front(); vec_cnt++;
            if (got !== e) begin miss_cnt++; $display("FAIL ring_lock[%0d] got %b expected %b", k, got, e); end
        end
        drive(1'b0, 1'b0, 5'b11111, 1'b0, E(2, 0, 1, 1, 0, 0));
        got = outs(); e = sb.pop_front(); vec_cnt++;
        if (got !== e) begin miss_cnt++; $display("FAIL ring_idle_hold got %b expected %b", got, e); end
    endtask

    task automatic test_locked_fault();
        logic [OW-1:0] got, e;
        logic [0:4] c [4] = '{5'b11000, 5'b00001, 5'b10000, 5'b00100};
        logic [OW-1:0] x [4];
        x[0] = E(2, 0, 0, 0, 1, 1);
        x[1] = E(4, 1, 1, 0, 0, 1);
        x[2] = E(0, 1, 1, 0, 0, 1);
        x[3] = E(2, 1, 1, 0, 0, 1);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, c[k], 1'b0, x[k]);
            got = outs(); e = sb.pop_front(); vec_cnt++;
            if (got !== e) begin miss_cnt++; $display("FAIL locked_fault[%0d] got %b expected %b", k, got, e); end
        end
    endtask

    task automatic test_johnson();
        logic [OW-1:0] got, e;
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 1'b1, jc[k % 10], 1'b0, E(k % 10, 1, 1, k >= 3, 0, 1));
            got = outs(); e = sb.pop_front(); vec_cnt++;
            if (got !== e) begin miss_cnt++; $display("FAIL johnson[%0d] got %b expected %b", k, got, e); end
        end
    endtask

    task automatic test_reset_mode();
        logic [OW-1:0] got, e;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, rc[k], 1'b0, E(k, 1, 1, k == 3, 0, 1));
            got = outs(); e = sb.pop_front(); vec_cnt++;
            if (got !== e) begin miss_cnt++; $display("FAIL pre_reset_lock[%0d] got %b expected %b", k, got, e); end
        end
        reset = 1'b0;
        sb.push_back(E(0, 0, 0, 0, 0, 0));
        #1;
        got = outs(); e = sb.pop_front(); vec_cnt++;
        if (got !== e) begin miss_cnt++; $display("FAIL async_reset got %b expected %b", got, e); end
        @(posedge clk); #1;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, rc[k], 1'b0, E(k, 1, 1, k == 3, 0, 0));
            got = outs(); e = sb.pop_front(); vec_cnt++;
            if (got !== e) begin miss_cnt++; $display("FAIL post_reset_lock[%0d] got %b expected %b", k, got, e); end
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, jc[k + 3], 1'b0, E(k + 3, 1, 1, k == 3, 0, 0));
            got = outs(); e = sb.pop_front(); vec_cnt++;
            if (got !== e) begin miss_cnt++; $display("FAIL mode_switch[%0d] got %b expected %b", k, got, e); end
        end
    endtask

    task automatic test_saturation();
        logic [OW-1:0] got, e;
        int cnt;
        for (int r = 0; r < 6; r++) begin
            cnt = (r < 3) ? r : 3;
            for (int s = 0; s < 4; s++) begin
                drive(1'b1, 1'b0, rc[s], 1'b0, E(s, 1, 1, s == 3, 0, cnt));
                got = outs(); e = sb.pop_front(); vec_cnt++;
                if (got !== e) begin miss_cnt++; $display("FAIL sat_lock[%0d.%0d] got %b expected %b", r, s, got, e); end
            end
            drive(1'b1, 1'b0, 5'b11111, r == 5, E(3, 0, 0, 0, 1, (r == 5) ? 0 : ((cnt < 3) ? cnt + 1 : 3)));
            got = outs(); e = sb.pop_front(); vec_cnt++;
            if (got !== e) begin miss_cnt++; $display("FAIL sat_fault[%0d] got %b expected %b", r, got, e); end
        end
    endtask

    task automatic test_stall();
        logic [OW-1:0] got, e;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, jc[k], 1'b0, E(k, 1, 1, k >= 3, 0, 0));
            got = outs(); e = sb.pop_front(); vec_cnt++;
            if (got !== e) begin miss_cnt++; $display("FAIL stall_lock[%0d] got %b expected %b", k, got, e); end
        end
`ifdef RJD_STALL_OK_EN
        drive(1'b1, 1'b1, 5'b11110, 1'b0, E(4, 0, 1, 1, 0, 0));
`else
        drive(1'b1, 1'b1, 5'b11110, 1'b0, E(4, 0, 1, 0, 1, 1));
`endif
        got = outs(); e = sb.pop_front(); vec_cnt++;
        if (got !== e) begin miss_cnt++; $display("FAIL stall_repeat got %b expected %b", got, e); end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_ring_lock();
        test_locked_fault();
        test_johnson();
        test_reset_mode();
        test_saturation();
        test_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, %0d of expected vectors seen", vec_cnt);
        $fatal(1);
    end

endmodule
